// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - bundled CPU/camera request ports and memory-side bus
//
// Purpose: groups the two requester ports and the shared memory bus into one bundle.
// Ports (signals):
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  -> arbiter   CPU load/store request
//   cpu_rdata/cpu_ack                  <- arbiter   CPU read data and completion pulse
//   cam_*                              same as cpu_*, for the camera frame-writer DMA
//   mem_addr/mem_wdata/mem_we/mem_sel  <- arbiter   latched access to RAM/FB/IO/ROM
//   mem_rdata                          -> arbiter   read data from the selected memory
//   busy                               <- arbiter   high while a transaction is in flight
// Modports: slave = arbiter view, master = requester/memory view.
interface mem_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          cam_req;
    logic          cam_we;
    logic [AW-1:0] cam_addr;
    logic [DW-1:0] cam_wdata;
    logic [DW-1:0] cam_rdata;
    logic          cam_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [3:0]    mem_sel;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cam_req, cam_we, cam_addr, cam_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_ack, cam_rdata, cam_ack,
        output mem_addr, mem_wdata, mem_we, mem_sel, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cam_req, cam_we, cam_addr, cam_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_ack, cam_rdata, cam_ack,
        input  mem_addr, mem_wdata, mem_we, mem_sel, busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin CPU/camera arbiter for the shared data-memory bus
//
// Purpose: grants the memory bus to the CPU (port 0) or camera DMA (port 1), latches the
// winner's access, decodes a one-hot region select, holds the bus for WAIT_CYC cycles and
// returns read data with a one-cycle ack.
// Ports:
//   clk      in  system clock, rising edge
//   reset_n  in  asynchronous active-low reset
//   bus      slave modport of mem_bus_arbiter_if (requester ports + memory bus)
module mem_bus_arbiter #(
    parameter int            AW       = 32,
    parameter int            DW       = 32,
    parameter logic [AW-1:0] LIMIT_A  = 'h0004_0000,
    parameter logic [AW-1:0] LIMIT_B  = 'h0008_0000,
    parameter logic [AW-1:0] LIMIT_C  = 'h0009_0000,
    parameter int            WAIT_CYC = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    mem_bus_arbiter_if.slave    bus
);
    localparam int CNTW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} stateType;

    stateType       state;
    stateType       nextState;
    logic [CNTW-1:0] cnt;
    logic           ownerQ;      // 0 = CPU, 1 = camera
    logic           lastGrant;   // same encoding as ownerQ
    logic [AW-1:0]  addrQ;
    logic [DW-1:0]  wdataQ;
    logic           weQ;
    logic [3:0]     selQ;
    logic [DW-1:0]  cpuRdataQ;
    logic [DW-1:0]  camRdataQ;

    logic           anyReq;
    logic           grantCam;
    logic [AW-1:0]  winAddr;
    logic [DW-1:0]  winWdata;
    logic           winWe;

    function automatic logic [3:0] decodeRegion(input logic [AW-1:0] a);
        if (a < LIMIT_A)      return 4'b1000;
        else if (a < LIMIT_B) return 4'b0001;
        else if (a < LIMIT_C) return 4'b0010;
        else                  return 4'b0100;
    endfunction

    // On a tie the port that did not win last time gets the bus.
    always_comb begin
        anyReq   = bus.cpu_req | bus.cam_req;
        grantCam = 1'b0;
        if (bus.cam_req && !bus.cpu_req)
            grantCam = 1'b1;
        else if (bus.cam_req && bus.cpu_req)
            grantCam = (lastGrant == 1'b0);
        winAddr  = grantCam ? bus.cam_addr  : bus.cpu_addr;
        winWdata = grantCam ? bus.cam_wdata : bus.cpu_wdata;
        winWe    = grantCam ? bus.cam_we    : bus.cpu_we;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (anyReq) nextState = ACCESS;
            ACCESS:  if (cnt == '0) nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            ownerQ    <= 1'b0;
            lastGrant <= 1'b1;
            addrQ     <= '0;
            wdataQ    <= '0;
            weQ       <= 1'b0;
            selQ      <= 4'b0000;
            cpuRdataQ <= '0;
            camRdataQ <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        ownerQ    <= grantCam;
                        lastGrant <= grantCam;
                        addrQ     <= winAddr;
                        wdataQ    <= winWdata;
                        weQ       <= winWe;
                        selQ      <= decodeRegion(winAddr);
                        cnt       <= CNTW'(WAIT_CYC - 1);
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        selQ <= 4'b0000;
                        if (!weQ) begin
                            if (ownerQ) camRdataQ <= bus.mem_rdata;
                            else        cpuRdataQ <= bus.mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - CNTW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // mem_we is gated by state so it drops the instant reset puts the FSM in IDLE.
    always_comb begin
        bus.busy      = (state != IDLE);
        bus.cpu_ack   = (state == RESP) && !ownerQ;
        bus.cam_ack   = (state == RESP) &&  ownerQ;
        bus.mem_we    = (state == ACCESS) && weQ;
        bus.mem_sel   = selQ;
        bus.mem_addr  = addrQ;
        bus.mem_wdata = wdataQ;
        bus.cpu_rdata = cpuRdataQ;
        bus.cam_rdata = camRdataQ;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
    localparam int          W  = 2;
    localparam logic [31:0] LA = 32'h0004_0000;
    localparam logic [31:0] LB = 32'h0008_0000;
    localparam logic [31:0] LC = 32'h0009_0000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    mem_bus_arbiter_if bus();

    mem_bus_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int testCount = 0;
    int failCount = 0;

    // Transaction-level model: a granted transfer occupies cycles 1..W of its
    // timeline on the bus, cycle W+1 is the ack, after which the bus is free.
    bit          active;
    int          phase;
    bit          owner;
    bit          lastG;
    bit          lWe;
    logic [31:0] lAddr;
    logic [31:0] lWdata;
    logic [31:0] mRd [2];
    int          ackOrder [$];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] regionOf(input logic [31:0] a);
        if (a < LA)      return 4'b1000;
        else if (a < LB) return 4'b0001;
        else if (a < LC) return 4'b0010;
        else             return 4'b0100;
    endfunction

    task automatic modelReset();
        active = 1'b0;
        phase  = 0;
        lastG  = 1'b1;
        mRd[0] = '0;
        mRd[1] = '0;
    endtask

    task automatic modelEdge();
        bit win;
        if (!reset_n) begin
            modelReset();
        end else if (!active) begin
            if (bus.cpu_req || bus.cam_req) begin
                if (bus.cpu_req && !bus.cam_req)      win = 1'b0;
                else if (bus.cam_req && !bus.cpu_req) win = 1'b1;
                else                                  win = !lastG;
                active = 1'b1;
                phase  = 1;
                owner  = win;
                lastG  = win;
                lAddr  = win ? bus.cam_addr  : bus.cpu_addr;
                lWdata = win ? bus.cam_wdata : bus.cpu_wdata;
                lWe    = win ? bus.cam_we    : bus.cpu_we;
            end
        end else if (phase < W) begin
            phase++;
        end else if (phase == W) begin
            if (!lWe) mRd[owner] = bus.mem_rdata;
            phase++;
        end else begin
            active = 1'b0;
            phase  = 0;
        end
    endtask

    task automatic checkOutputs();
        bit acc;
        bit rsp;
        acc = active && (phase >= 1) && (phase <= W);
        rsp = active && (phase == W + 1);
        checkVal("busy", 32'(bus.busy), 32'(active));
        checkVal("mem_sel", 32'(bus.mem_sel), acc ? 32'(regionOf(lAddr)) : 32'd0);
        checkVal("mem_we", 32'(bus.mem_we), 32'(acc && lWe));
        if (acc) begin
            checkVal("mem_addr", bus.mem_addr, lAddr);
            checkVal("mem_wdata", bus.mem_wdata, lWdata);
        end
        checkVal("cpu_ack", 32'(bus.cpu_ack), 32'(rsp && !owner));
        checkVal("cam_ack", 32'(bus.cam_ack), 32'(rsp && owner));
        checkVal("cpu_rdata", bus.cpu_rdata, mRd[0]);
        checkVal("cam_rdata", bus.cam_rdata, mRd[1]);
    endtask

    task automatic runCycle();
        modelEdge();
        @(posedge clk);
        @(negedge clk);
        checkOutputs();
        if (bus.cpu_ack) ackOrder.push_back(0);
        if (bus.cam_ack) ackOrder.push_back(1);
    endtask

    function automatic logic [31:0] randAddr();
        case ($urandom_range(0, 5))
            0:       return $urandom;
            1:       return LA - 32'd1 + 32'($urandom_range(0, 1));
            2:       return LB - 32'd1 + 32'($urandom_range(0, 1));
            3:       return LC - 32'd1 + 32'($urandom_range(0, 1));
            4:       return 32'($urandom_range(0, 32'h000A_0000));
            default: return 32'hFFFF_FFFC;
        endcase
    endfunction

    // Requesters hold a pending request steady until acked; the owner scrambles its
    // inputs mid-transaction (must have no effect), and after an ack a port may re-request.
    task automatic driveRandom();
        bit acc;
        bit rsp;
        acc = active && (phase <= W);
        rsp = active && (phase == W + 1);
        if ((acc || rsp) && owner == 1'b0 || (!bus.cpu_req && $urandom_range(0, 9) < 3)) begin
            bus.cpu_req   = (acc || rsp) && owner == 1'b0 ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.cpu_we    = 1'($urandom_range(0, 1));
            bus.cpu_addr  = randAddr();
            bus.cpu_wdata = $urandom;
        end
        if ((acc || rsp) && owner == 1'b1 || (!bus.cam_req && $urandom_range(0, 9) < 3)) begin
            bus.cam_req   = (acc || rsp) && owner == 1'b1 ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.cam_we    = 1'($urandom_range(0, 1));
            bus.cam_addr  = randAddr();
            bus.cam_wdata = $urandom;
        end
        bus.mem_rdata = $urandom;
    endtask

    initial begin
        logic [31:0] bndAddr [4];
        logic [3:0]  bndSel  [4];
        bit          seen;

        bndAddr = '{32'h0003_FFFF, 32'h0008_0000, 32'h0008_FFFF, 32'h0009_0000};
        bndSel  = '{4'b1000, 4'b0010, 4'b0010, 4'b0100};

        // Reset with both ports requesting.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_0010; bus.cpu_wdata = '0;
        bus.cam_req = 1'b1; bus.cam_we = 1'b1; bus.cam_addr = 32'h0004_0000; bus.cam_wdata = 32'h1234;
        bus.mem_rdata = 32'hDEAD_BEEF;
        modelReset();
        repeat (2) runCycle();
        checkVal("rst_mem_addr", bus.mem_addr, 32'd0);
        checkVal("rst_mem_wdata", bus.mem_wdata, 32'd0);

        // Both held: CPU read / camera write alternate, CPU first.
        reset_n = 1'b1;
        ackOrder.delete();
        repeat (16) runCycle();
        bus.cpu_req = 1'b0;
        bus.cam_req = 1'b0;
        repeat (2) runCycle();
        checkVal("ack_count", 32'(ackOrder.size()), 32'd4);
        for (int i = 0; i < 4 && i < ackOrder.size(); i++)
            checkVal($sformatf("ack_order%0d", i), 32'(ackOrder[i]), 32'(i % 2));
        checkVal("dir_cpu_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
        checkVal("dir_cam_rdata", bus.cam_rdata, 32'd0);

        // Region boundaries.
        for (int i = 0; i < 4; i++) begin
            bus.cpu_req  = 1'b1;
            bus.cpu_we   = 1'b0;
            bus.cpu_addr = bndAddr[i];
            seen = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                runCycle();
                if (active && phase == 1)
                    checkVal($sformatf("bnd_sel%0d", i), 32'(bus.mem_sel), 32'(bndSel[i]));
                if (bus.cpu_ack) begin
                    seen = 1'b1;
                    bus.cpu_req = 1'b0;
                end
            end
            if (!seen) checkVal("bnd_ack_timeout", 32'd0, 32'd1);
        end

        // Reset during the second ACCESS cycle of a camera write.
        repeat (2) runCycle();
        bus.cam_req = 1'b1; bus.cam_we = 1'b1; bus.cam_addr = 32'h0000_0100; bus.cam_wdata = 32'hA5A5_A5A5;
        runCycle();
        runCycle();
        checkVal("mid_phase_we", 32'(bus.mem_we), 32'd1);
        bus.cam_req = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        checkVal("mid_rst_we", 32'(bus.mem_we), 32'd0);
        checkVal("mid_rst_sel", 32'(bus.mem_sel), 32'd0);
        checkVal("mid_rst_busy", 32'(bus.busy), 32'd0);
        modelReset();
        runCycle();
        reset_n = 1'b1;
        ackOrder.delete();
        repeat (4) runCycle();
        checkVal("mid_rst_no_ack", 32'(ackOrder.size()), 32'd0);

        // Randomized traffic.
        repeat (3000) begin
            driveRandom();
            runCycle();
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
